// File: rtl/muldiv_stall_ctrl_if.sv
// Execute-stage handshake between the pipeline and the mul/div stall controller.
// The slave side is the controller. The master side is the pipeline or hazard unit.
interface muldiv_stall_ctrl_if;
    logic        MulDivE;
    logic        IsDivE;
    logic        KillE;
    logic        lwstall;
    logic        md_early;
    logic        md_start;
    logic        md_abort;
    logic        md_capture;
    logic        md_busy;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushM;
    logic [31:0] md_stall_cnt;

    modport master (
        output MulDivE, IsDivE, KillE, lwstall, md_early,
        input  md_start, md_abort, md_capture, md_busy,
               StallF, StallD, StallE, FlushM, md_stall_cnt
    );

    modport slave (
        input  MulDivE, IsDivE, KillE, lwstall, md_early,
        output md_start, md_abort, md_capture, md_busy,
               StallF, StallD, StallE, FlushM, md_stall_cnt
    );
endinterface

// File: rtl/muldiv_stall_ctrl.sv
// Sequences the shared iterative mul/div unit from E. It freezes F/D/E and bubbles M
// while the unit runs, then releases the pipeline on the capture cycle.
module muldiv_stall_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_stall_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             mdStall, start, abort, capture;
    logic [31:0]      stallCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (mdStall && stallCnt != 32'hFFFF_FFFF)
                stallCnt <= stallCnt + 32'd1;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mdStall   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MulDivE && !bus.KillE) begin
                    start     = 1'b1;
                    mdStall   = 1'b1;
                    cntNext   = bus.IsDivE ? DIV_INIT : MUL_INIT;
                    stateNext = RUN;
                end
            end
            RUN: begin
                // A squash wins over completion, even if the unit is finishing this cycle.
                if (bus.KillE) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                end else begin
                    mdStall = 1'b1;
                    if (bus.md_early || cnt == '0)
                        stateNext = DONE;
                    else
                        cntNext = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // MulDivE still shows the finished instruction here, so it must not restart.
                capture   = ~bus.KillE;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Gate the outputs with reset so that nothing leaks from live inputs while reset is held.
    assign bus.md_start     = rst & start;
    assign bus.md_abort     = rst & abort;
    assign bus.md_capture   = rst & capture;
    assign bus.md_busy      = rst & (state != IDLE);
    assign bus.StallF       = rst & (bus.lwstall | mdStall);
    assign bus.StallD       = rst & (bus.lwstall | mdStall);
    assign bus.StallE       = rst & mdStall;
    assign bus.FlushM       = rst & mdStall;
    assign bus.md_stall_cnt = stallCnt;
endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// Directed bench for muldiv_stall_ctrl at the default latencies (MUL_LAT=2, DIV_LAT=32).
// Output vector order: {md_start, md_abort, md_capture, md_busy, StallF, StallD, StallE, FlushM}.
module tb_muldiv_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    muldiv_stall_ctrl_if bus ();

    muldiv_stall_ctrl #(.MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Input vector order: {MulDivE, IsDivE, KillE, lwstall, md_early}.
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_MUL  = 5'b10000;
    localparam logic [4:0] I_DIV  = 5'b11000;
    localparam logic [4:0] I_KILL = 5'b00100;
    localparam logic [4:0] I_LW   = 5'b00010;
    localparam logic [4:0] I_ERLY = 5'b00001;

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_START = 8'b1000_1111;
    localparam logic [7:0] O_RUN   = 8'b0001_1111;
    localparam logic [7:0] O_CAP   = 8'b0011_0000;
    localparam logic [7:0] O_ABORT = 8'b0101_0000;
    localparam logic [7:0] O_LW    = 8'b0000_1100;

    logic [7:0] outs;
    assign outs = {bus.md_start, bus.md_abort, bus.md_capture, bus.md_busy,
                   bus.StallF, bus.StallD, bus.StallE, bus.FlushM};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic [4:0] in);
        {bus.MulDivE, bus.IsDivE, bus.KillE, bus.lwstall, bus.md_early} = in;
    endtask

    // One cycle: apply inputs just after the rising edge and check on the falling edge.
    task automatic step(input string tag, input logic [4:0] in, input logic [7:0] exp);
        setIn(in);
        @(negedge clk);
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIn(I_MUL);
        // While reset is held, every output stays 0 even with a mul/div op present.
        @(negedge clk);
        chk("reset_outs", {24'd0, outs}, 32'd0);
        chk("reset_cnt", bus.md_stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("idle", I_NONE, O_IDLE);

        // Multiply: start at 0, run for 2 cycles, capture at 3.
        step("mul_c0", I_MUL, O_START);
        step("mul_c1", I_MUL, O_RUN);
        step("mul_c2", I_MUL, O_RUN);
        setIn(I_MUL);
        @(negedge clk);
        chk("mul_c3", {24'd0, outs}, {24'd0, O_CAP});
        chk("mul_cnt", bus.md_stall_cnt, 32'd3);
        @(posedge clk);
        #1;
        step("mul_c4", I_NONE, O_IDLE);

        // Divide: start at 0, run for cycles 1..32, capture at 33.
        step("div_c0", I_DIV, O_START);
        for (int i = 1; i <= 32; i++) step("div_run", I_DIV, O_RUN);
        setIn(I_DIV);
        @(negedge clk);
        chk("div_c33", {24'd0, outs}, {24'd0, O_CAP});
        chk("div_cnt", bus.md_stall_cnt, 32'd36);
        @(posedge clk);
        #1;
        step("div_c34", I_NONE, O_IDLE);

        // Divide that finishes early: md_early in cycle 5, capture in 6, idle in 7.
        step("erl_c0", I_DIV, O_START);
        for (int i = 1; i <= 4; i++) step("erl_run", I_DIV, O_RUN);
        step("erl_c5", I_DIV | I_ERLY, O_RUN);
        step("erl_c6", I_DIV, O_CAP);
        setIn(I_NONE);
        @(negedge clk);
        chk("erl_c7", {24'd0, outs}, {24'd0, O_IDLE});
        chk("erl_cnt", bus.md_stall_cnt, 32'd42);
        @(posedge clk);
        #1;

        // Squash in cycle 10 of a divide: abort, stalls drop, no capture follows.
        step("kill_c0", I_DIV, O_START);
        for (int i = 1; i <= 9; i++) step("kill_run", I_DIV, O_RUN);
        step("kill_c10", I_DIV | I_KILL, O_ABORT);
        setIn(I_NONE);
        @(negedge clk);
        chk("kill_c11", {24'd0, outs}, {24'd0, O_IDLE});
        chk("kill_cnt", bus.md_stall_cnt, 32'd52);
        @(posedge clk);
        #1;

        // A killed op in IDLE must not start.
        step("kill_idle", I_MUL | I_KILL, O_IDLE);

        // Back-to-back muls. IsDivE toggles mid-run, and only its value at start matters.
        step("b2b_c0", I_MUL, O_START);
        step("b2b_c1", I_DIV, O_RUN);
        step("b2b_c2", I_DIV, O_RUN);
        step("b2b_c3", I_MUL, O_CAP);
        step("b2b_c4", I_MUL, O_START);
        step("b2b_c5", I_MUL, O_RUN);
        step("b2b_c6", I_MUL, O_RUN);
        step("b2b_c7", I_MUL, O_CAP);
        setIn(I_NONE);
        @(negedge clk);
        chk("b2b_cnt", bus.md_stall_cnt, 32'd58);
        @(posedge clk);
        #1;

        // A load-use stall passes straight through, both when idle and while running.
        step("lw_idle", I_LW, O_LW);
        step("lw_c0", I_MUL | I_LW, O_START);
        step("lw_c1", I_MUL | I_LW, O_RUN);
        step("lw_c2", I_MUL, O_RUN);
        step("lw_c3", I_MUL | I_LW, O_CAP | O_LW);
        step("lw_c4", I_NONE, O_IDLE);

        // Reset asserted during RUN: outputs drop at once, then a clean mul runs after release.
        step("rst_c0", I_DIV, O_START);
        for (int i = 1; i <= 3; i++) step("rst_run", I_DIV, O_RUN);
        rst = 1'b0;
        setIn(I_DIV);
        @(negedge clk);
        chk("rst_mid_outs", {24'd0, outs}, 32'd0);
        chk("rst_mid_cnt", bus.md_stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("rst_idle", I_NONE, O_IDLE);
        step("rst_mul_c0", I_MUL, O_START);
        step("rst_mul_c1", I_MUL, O_RUN);
        step("rst_mul_c2", I_MUL, O_RUN);
        setIn(I_MUL);
        @(negedge clk);
        chk("rst_mul_c3", {24'd0, outs}, {24'd0, O_CAP});
        chk("rst_mul_cnt", bus.md_stall_cnt, 32'd3);
        @(posedge clk);
        #1;
        step("rst_mul_c4", I_NONE, O_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
